// File: rtl/demux_sel_sequencer_pkg.sv
// demux_seq_pkg: shared types, constants and lane-search helpers for the
// demux select sequencer.
package demux_seq_pkg;

  localparam int SEL_W = 3;
  localparam int NCH   = 8;

  typedef struct packed {
    logic [2:0] addr;
    logic       data;
  } seq_item_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_PAUSE = 2'd2
  } seq_state_t;

  // First enabled lane at or after 'start', wrapping. Returns {found, lane}.
  function automatic logic [3:0] next_lane(input logic [NCH-1:0] mask,
                                           input logic [SEL_W-1:0] start);
    logic [3:0]       res;
    logic [SEL_W-1:0] idx;
    res = 4'b0000;
    // Walk from the farthest offset down so the nearest enabled lane wins.
    for (int i = NCH - 1; i >= 0; i--) begin
      idx = start + 3'(i);
      if (mask[idx]) begin
        res = {1'b1, idx};
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  // Highest-numbered enabled lane (0 when nothing is enabled).
  function automatic logic [SEL_W-1:0] highest_lane(input logic [NCH-1:0] mask);
    logic [SEL_W-1:0] res;
    res = 3'd0;
    for (int i = 0; i < NCH; i++) begin
      if (mask[i]) begin
        res = 3'(i);
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/demux_sel_sequencer_fifo.sv
// seq_fifo: synchronous FIFO of seq_item_t with occupancy count and
// full/empty flags. Synchronous active-low reset flushes the pointers.
module seq_fifo
  import demux_seq_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  seq_item_t                wdata,
  output seq_item_t                rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  seq_item_t         mem_q [DEPTH];
  seq_item_t         mem_d [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;

  // Next-state of storage, pointers and occupancy.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer/count registers with synchronous flush; storage needs no reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      count_q  <= {CW{1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
    mem_q <= mem_d;
  end

  assign rdata = mem_q[rd_ptr_q];
  assign count = count_q;
  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == {CW{1'b0}});

endmodule

// File: rtl/demux_sel_sequencer.sv
// demux_sel_sequencer: buffers a handshaked 1-bit stream and issues at most
// one item per cycle as {select, data} for a 1-to-8 demux tree, either
// round-robin over the lanes or addressed by each item's destination tag.
// Optional feature macro SEQ_CH_MASK_EN adds a lane-enable mask (ch_mask)
// and a drop pulse for items that cannot be delivered.
module demux_sel_sequencer
  import demux_seq_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     in_data,
  input  logic [SEL_W-1:0]         in_addr,
  input  logic                     mode,
  input  logic                     hold,
`ifdef SEQ_CH_MASK_EN
  input  logic [NCH-1:0]           ch_mask,
  output logic                     drop,
`endif
  output logic [SEL_W-1:0]         out_sel,
  output logic                     out_data,
  output logic                     out_valid,
  output logic                     frame_done,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int CW = $clog2(DEPTH) + 1;

  seq_item_t         entry_s;
  seq_item_t         wr_item_s;
  logic [CW-1:0]     count_s;
  logic              full_s, empty_s;
  logic              push_s, pop_s;
  logic [NCH-1:0]    mask_s;
  logic [3:0]        rr_pick_s, rr_next_s;
  logic [SEL_W-1:0]  lane_s;
  logic              lane_en_s, issue_s, drop_s, will_empty_s;

  seq_state_t        state_q, state_d;
  logic [SEL_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [SEL_W-1:0]  out_sel_q, out_sel_d;
  logic              out_data_q, out_data_d;
  logic              out_valid_q, out_valid_d;
  logic              frame_done_q, frame_done_d;
  logic              drop_q, drop_d;

`ifdef SEQ_CH_MASK_EN
  assign mask_s = ch_mask;
  assign drop   = drop_q;
`else
  assign mask_s = 8'hFF;
`endif

  // No full-bypass: a pop in the same cycle does not open the door.
  assign in_ready  = rst_n & ~full_s;
  assign push_s    = in_valid & in_ready;
  assign pop_s     = ~empty_s & ~hold;
  assign wr_item_s = '{addr: in_addr, data: in_data};

  seq_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_s),
    .pop   (pop_s),
    .wdata (wr_item_s),
    .rdata (entry_s),
    .count (count_s),
    .full  (full_s),
    .empty (empty_s)
  );

  // Lane choice for the head entry and the round-robin pointer advance.
  always_comb begin
    rr_pick_s = next_lane(mask_s, rr_ptr_q);
    rr_next_s = next_lane(mask_s, rr_pick_s[2:0] + 3'd1);
    rr_ptr_d  = rr_ptr_q;
    if (mode) begin
      lane_s    = entry_s.addr;
      lane_en_s = mask_s[entry_s.addr];
    end else begin
      lane_s    = rr_pick_s[2:0];
      lane_en_s = rr_pick_s[3];
      if (pop_s && rr_next_s[3]) begin
        rr_ptr_d = rr_next_s[2:0];
      end else begin
        rr_ptr_d = rr_ptr_q;
      end
    end
  end

  // Output register next-values; select holds when nothing is issued.
  always_comb begin
    issue_s      = pop_s & lane_en_s;
    drop_s       = pop_s & ~lane_en_s;
    out_valid_d  = issue_s;
    out_data_d   = issue_s & entry_s.data;
    frame_done_d = issue_s & ~mode & (lane_s == highest_lane(mask_s));
    drop_d       = drop_s;
    if (issue_s) begin
      out_sel_d = lane_s;
    end else begin
      out_sel_d = out_sel_q;
    end
  end

  // Sequencer state: idle when the FIFO will be empty, paused on hold.
  always_comb begin
    will_empty_s = ((count_s == CW'(0)) & ~push_s) |
                   ((count_s == CW'(1)) & pop_s & ~push_s);
    case (state_q)
      S_IDLE: begin
        if (hold)              state_d = S_PAUSE;
        else if (!will_empty_s) state_d = S_ISSUE;
        else                   state_d = S_IDLE;
      end
      S_ISSUE: begin
        if (hold)              state_d = S_PAUSE;
        else if (will_empty_s) state_d = S_IDLE;
        else                   state_d = S_ISSUE;
      end
      S_PAUSE: begin
        if (hold)              state_d = S_PAUSE;
        else if (will_empty_s) state_d = S_IDLE;
        else                   state_d = S_ISSUE;
      end
      default:                 state_d = S_IDLE;
    endcase
  end

  // State, round-robin pointer and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      rr_ptr_q     <= 3'd0;
      out_sel_q    <= 3'd0;
      out_data_q   <= 1'b0;
      out_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      drop_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      out_sel_q    <= out_sel_d;
      out_data_q   <= out_data_d;
      out_valid_q  <= out_valid_d;
      frame_done_q <= frame_done_d;
      drop_q       <= drop_d;
    end
  end

  assign out_sel    = out_sel_q;
  assign out_data   = out_data_q;
  assign out_valid  = out_valid_q;
  assign frame_done = frame_done_q;
  assign fifo_count = count_s;

`ifndef SEQ_CH_MASK_EN
  // Drop can never fire without a mask; keep the register referenced.
  logic unused_s;
  assign unused_s = drop_q;
`endif

endmodule

// File: tb/tb_demux_sel_sequencer.sv
// Self-checking bench for demux_sel_sequencer: directed scenarios followed by
// randomized traffic, all compared against a queue-based reference model.
module tb_demux_sel_sequencer;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic       in_data = 1'b0;
  logic [2:0] in_addr = 3'd0;
  logic       mode = 1'b0;
  logic       hold = 1'b0;
  logic [2:0] out_sel;
  logic       out_data, out_valid, frame_done;
  logic [2:0] fifo_count;
  logic [7:0] mask_v = 8'hFF;
`ifdef SEQ_CH_MASK_EN
  logic       drop;
`endif

  always #5 clk = ~clk;

  demux_sel_sequencer #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_addr    (in_addr),
    .mode       (mode),
    .hold       (hold),
`ifdef SEQ_CH_MASK_EN
    .ch_mask    (mask_v),
    .drop       (drop),
`endif
    .out_sel    (out_sel),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .frame_done (frame_done),
    .fifo_count (fifo_count)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model: a queue of {addr,data} items and a lane counter.
  logic [3:0] mq[$];
  int         m_rr = 0;
  logic [2:0] e_sel = 3'd0;
  logic       e_valid = 1'b0, e_data = 1'b0, e_fd = 1'b0, e_drop = 1'b0;

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_update(input logic rn, input logic iv, input logic id,
                              input logic [2:0] ia, input logic md, input logic hd);
    logic [3:0] it;
    int  lane, hi, c;
    bit  en, found, rdy;
    if (!rn) begin
      mq.delete();
      m_rr = 0;
      e_sel = 3'd0; e_valid = 1'b0; e_data = 1'b0; e_fd = 1'b0; e_drop = 1'b0;
    end else begin
      rdy = (mq.size() < DEPTH);
      e_valid = 1'b0; e_data = 1'b0; e_fd = 1'b0; e_drop = 1'b0;
      if (mq.size() > 0 && !hd) begin
        it = mq.pop_front();
        lane = 0; en = 0;
        if (md) begin
          lane = int'(it[3:1]);
          en = mask_v[lane];
        end else begin
          for (int off = 0; off < 8; off++) begin
            c = (m_rr + off) % 8;
            if (!en && mask_v[c]) begin lane = c; en = 1; end
          end
          if (en) begin
            found = 0;
            for (int off = 1; off <= 8; off++) begin
              c = (lane + off) % 8;
              if (!found && mask_v[c]) begin m_rr = c; found = 1; end
            end
          end
        end
        hi = 0;
        for (int i = 0; i < 8; i++) if (mask_v[i]) hi = i;
        if (en) begin
          e_valid = 1'b1;
          e_data  = it[0];
          e_sel   = 3'(lane);
          e_fd    = !md && (lane == hi);
        end else begin
          e_drop = 1'b1;
        end
      end
      if (iv && rdy) mq.push_back({ia, id});
    end
  endtask

  // One clock cycle: drive, check ready, advance model, sample after the edge.
  task automatic step(input logic rn, input logic iv, input logic id,
                      input logic [2:0] ia, input logic md, input logic hd);
    bit exp_rdy;
    rst_n = rn; in_valid = iv; in_data = id; in_addr = ia; mode = md; hold = hd;
    #1;
    exp_rdy = rn && (mq.size() < DEPTH);
    check_eq("in_ready", 8'(in_ready), 8'(exp_rdy));
    model_update(rn, iv, id, ia, md, hd);
    @(posedge clk);
    #1;
    check_eq("out_valid", 8'(out_valid), 8'(e_valid));
    check_eq("out_data", 8'(out_data), 8'(e_data));
    check_eq("out_sel", 8'(out_sel), 8'(e_sel));
    check_eq("frame_done", 8'(frame_done), 8'(e_fd));
    check_eq("fifo_count", 8'(fifo_count), 8'(mq.size()));
`ifdef SEQ_CH_MASK_EN
    check_eq("drop", 8'(drop), 8'(e_drop));
`endif
  endtask

  task automatic idle(input int n, input logic md);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 3'd0, md, 1'b0);
  endtask

  initial begin
    logic [7:0] pat;
    logic [2:0] aa [3];
    logic       ad [3];
    int         r;
    pat = 8'b1010_1101;
    aa[0] = 3'd5; aa[1] = 3'd2; aa[2] = 3'd5;
    ad[0] = 1'b1; ad[1] = 1'b1; ad[2] = 1'b0;

    // Reset state.
    step(1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);

    // Round-robin burst of 8 back-to-back items.
    for (int i = 0; i < 8; i++) step(1'b1, 1'b1, pat[i], 3'd0, 1'b0, 1'b0);
    idle(3, 1'b0);

    // Addressed items.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, ad[i], aa[i], 1'b1, 1'b0);
    idle(3, 1'b1);

    // Fill under hold, offer a fifth item, then drain.
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'(i), 3'd0, 1'b0, 1'b1);
    idle(6, 1'b0);

    // Reset with three items buffered, then one RR item.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b1, 3'd0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 3'd0, 1'b0, 1'b0);
    idle(3, 1'b0);

    // Hold toggled for two cycles in the middle of an RR burst.
    for (int i = 0; i < 10; i++)
      step(1'b1, 1'b1, pat[i % 8], 3'd0, 1'b0, (i == 4 || i == 5));
    idle(8, 1'b0);

`ifdef SEQ_CH_MASK_EN
    // Sparse lane mask in RR mode, then an item addressed to a disabled lane.
    mask_v = 8'b1010_0101;
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b1, 3'd0, 1'b0, 1'b0);
    idle(3, 1'b0);
    step(1'b1, 1'b1, 1'b1, 3'd1, 1'b1, 1'b0);
    idle(3, 1'b1);
    mask_v = 8'h00;
    for (int i = 0; i < 2; i++) step(1'b1, 1'b1, 1'b1, 3'd0, 1'b0, 1'b0);
    idle(3, 1'b0);
    mask_v = 8'hFF;
`endif

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
`ifdef SEQ_CH_MASK_EN
      if ($urandom_range(0, 99) == 0) begin
        r = $urandom_range(0, 3);
        mask_v = (r == 0) ? 8'hFF : (r == 1) ? 8'h00 : 8'($urandom);
      end
`endif
      step(($urandom_range(0, 63) != 0),
           ($urandom_range(0, 3) != 0),
           1'($urandom),
           3'($urandom),
           ($urandom_range(0, 2) == 0),
           ($urandom_range(0, 3) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
